ram_arbiter: RTL and testbench

- Arbitrates one asynchronous external SRAM (16-bit data, 18-bit address, active-low EN/OE/WE) between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- Runs a multi-cycle SRAM access sequence.
- Raises Stall to freeze pc/if_id/id_ex/ex_mem/mem_wb while any request is outstanding.
- Lets instructions and data share a single RAM chip.

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_sram_cycle.sv | 107 ++++++++++
 rtl/ram_arbiter.sv | 119 +++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the SRAM arbiter: the access-sequence state
//   encoding, the grant identifiers and the address widths used to pad the
//   16-bit port address out to the SRAM address bus.
package ram_arbiter_pkg;

  // Width of the word address presented by the fetch and data ports.
  localparam int PORT_ADDR_W = 16;
  // Zero bits prepended to the port address to form the SRAM address.
  localparam int ADDR_PAD_W = 2;

  // Access sequence states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } cycleState_e;

  // Which port owns the access currently in flight.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_e;

endpackage

// File: rtl/ram_arbiter_sram_cycle.sv
// sram_cycle
//   Timing engine for one asynchronous SRAM access. Leaves IDLE on start,
//   spends one SETUP cycle, WAIT_CYC STROBE cycles and one DONE (hold) cycle,
//   then returns to IDLE. All SRAM strobes are decoded from the state
//   register and the latched command, never from live requests.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin an access (only honoured in IDLE)
//   cmdWe     : latched command, 1 = write
//   idle      : sequencer is in IDLE and can accept a grant
//   ramEn/Oe/We : active-low SRAM strobes
//   busDrive  : drive the SRAM data bus with the latched write data
//   capture   : last STROBE cycle of a read; sample the bus at this edge
//   done      : DONE cycle; acknowledge the granted port
module sram_cycle
  import ram_arbiter_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cmdWe,
  output logic idle,
  output logic ramEn,
  output logic ramOe,
  output logic ramWe,
  output logic busDrive,
  output logic capture,
  output logic done
);

  // Counter starts at WAIT_CYC-1 so the STROBE phase lasts WAIT_CYC cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYC - 1);

  cycleState_e state;
  cycleState_e stateNext;
  logic [2:0]  waitCnt;
  logic [2:0]  waitCntNext;

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 3'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    idle        = 1'b0;
    ramEn       = 1'b1;
    ramOe       = 1'b1;
    ramWe       = 1'b1;
    busDrive    = 1'b0;
    capture     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) begin
          stateNext = SETUP;
        end else begin
          stateNext = IDLE;
        end
      end
      SETUP: begin
        // Address (and write data) settle before the strobe falls.
        ramEn       = 1'b0;
        ramOe       = cmdWe;
        busDrive    = cmdWe;
        waitCntNext = WAIT_LOAD;
        stateNext   = STROBE;
      end
      STROBE: begin
        ramEn    = 1'b0;
        ramOe    = cmdWe;
        ramWe    = ~cmdWe;
        busDrive = cmdWe;
        if (waitCnt == 3'd0) begin
          capture   = ~cmdWe;
          stateNext = DONE;
        end else begin
          waitCntNext = waitCnt - 3'd1;
          stateNext   = STROBE;
        end
      end
      DONE: begin
        // Strobes released but chip select, address and data held one more
        // cycle to satisfy SRAM hold time.
        ramEn     = 1'b0;
        busDrive  = cmdWe;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one asynchronous SRAM between the instruction-fetch port and the
//   data-memory port of the pipeline. Data has fixed priority over fetch.
//   Stall holds the pipeline while any request is outstanding.
// Ports:
//   Clk, Rst          : clock, asynchronous active-high reset
//   If_req/If_addr    : fetch request (held until If_ack) and word address
//   If_data/If_ack    : registered fetch data, valid with the one-cycle ack
//   Dm_req/Dm_we/Dm_addr/Dm_wdata : data request, 1 = write, address, data
//   Dm_rdata/Dm_ack   : registered read data, valid with the one-cycle ack
//   Stall             : pipeline freeze
//   Ram_EN/OE/WE      : active-low SRAM controls
//   Ram_address       : zero-padded latched address
//   Ram_data          : bidirectional SRAM data bus, driven only for writes
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = PORT_ADDR_W + ADDR_PAD_W,
  parameter int DATA_W   = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   If_req,
  input  logic [PORT_ADDR_W-1:0] If_addr,
  output logic [DATA_W-1:0]      If_data,
  output logic                   If_ack,
  input  logic                   Dm_req,
  input  logic                   Dm_we,
  input  logic [PORT_ADDR_W-1:0] Dm_addr,
  input  logic [DATA_W-1:0]      Dm_wdata,
  output logic [DATA_W-1:0]      Dm_rdata,
  output logic                   Dm_ack,
  output logic                   Stall,
  output logic                   Ram_EN,
  output logic                   Ram_OE,
  output logic                   Ram_WE,
  output logic [ADDR_W-1:0]      Ram_address,
  inout  wire  [DATA_W-1:0]      Ram_data
);

  grant_e                 grant;
  logic [PORT_ADDR_W-1:0] addrLatch;
  logic                   weLatch;
  logic [DATA_W-1:0]      wdataLatch;

  logic seqIdle;
  logic seqStart;
  logic busDrive;
  logic capture;
  logic seqDone;

  assign seqStart = seqIdle & (Dm_req | If_req);

  sram_cycle #(
    .WAIT_CYC (WAIT_CYC)
  ) u_sramCycle (
    .clk      (Clk),
    .rst      (Rst),
    .start    (seqStart),
    .cmdWe    (weLatch),
    .idle     (seqIdle),
    .ramEn    (Ram_EN),
    .ramOe    (Ram_OE),
    .ramWe    (Ram_WE),
    .busDrive (busDrive),
    .capture  (capture),
    .done     (seqDone)
  );

  // Grant and command latches; only updated in IDLE so later input changes
  // cannot disturb an access in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      grant      <= GNT_NONE;
      addrLatch  <= {PORT_ADDR_W{1'b0}};
      weLatch    <= 1'b0;
      wdataLatch <= {DATA_W{1'b0}};
    end else if (seqIdle) begin
      // Data port wins: its access belongs to the older instruction.
      if (Dm_req) begin
        grant      <= GNT_DM;
        addrLatch  <= Dm_addr;
        weLatch    <= Dm_we;
        wdataLatch <= Dm_wdata;
      end else if (If_req) begin
        grant     <= GNT_IF;
        addrLatch <= If_addr;
        weLatch   <= 1'b0;
      end
    end else if (seqDone) begin
      grant <= GNT_NONE;
    end
  end

  // Read-data demux: only the granted port's register is written.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      If_data  <= {DATA_W{1'b0}};
      Dm_rdata <= {DATA_W{1'b0}};
    end else if (capture) begin
      case (grant)
        GNT_DM:  Dm_rdata <= Ram_data;
        GNT_IF:  If_data  <= Ram_data;
        default: ;
      endcase
    end
  end

  assign If_ack = seqDone && (grant == GNT_IF);
  assign Dm_ack = seqDone && (grant == GNT_DM);

  // Drops in the ack cycle so the pipeline advances once per access.
  assign Stall = (Dm_req & ~Dm_ack) | (If_req & ~If_ack);

  assign Ram_address = {{(ADDR_W - PORT_ADDR_W){1'b0}}, addrLatch};
  assign Ram_data    = busDrive ? wdataLatch : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter. Instance u0 uses WAIT_CYC=1, instance u3
//   uses WAIT_CYC=3; each has its own behavioural SRAM. Cycle 0 of a scenario
//   is the cycle in which the request is first presented in IDLE; outputs are
//   sampled on the falling clock edge.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;

  // ---------------- instance u0 (WAIT_CYC = 1) ----------------
  logic        ifReq0 = 1'b0, dmReq0 = 1'b0, dmWe0 = 1'b0;
  logic [15:0] ifAddr0 = 16'h0, dmAddr0 = 16'h0, dmWdata0 = 16'h0;
  logic [15:0] ifData0, dmRdata0;
  logic        ifAck0, dmAck0, stall0, ramEn0, ramOe0, ramWe0;
  logic [17:0] ramAddr0;
  wire  [15:0] ramData0;
  logic [15:0] mem0 [0:255];

  ram_arbiter #(.WAIT_CYC(1)) u0 (
    .Clk(clk), .Rst(rst),
    .If_req(ifReq0), .If_addr(ifAddr0), .If_data(ifData0), .If_ack(ifAck0),
    .Dm_req(dmReq0), .Dm_we(dmWe0), .Dm_addr(dmAddr0), .Dm_wdata(dmWdata0),
    .Dm_rdata(dmRdata0), .Dm_ack(dmAck0), .Stall(stall0),
    .Ram_EN(ramEn0), .Ram_OE(ramOe0), .Ram_WE(ramWe0),
    .Ram_address(ramAddr0), .Ram_data(ramData0)
  );

  assign ramData0 = (!ramEn0 && !ramOe0 && ramWe0) ? mem0[ramAddr0[7:0]] : 16'hzzzz;

  // SRAM model u0: contents preloaded while reset is held, written while WE low.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 16'h0000;
      mem0[8'h10] <= 16'hBEEF;
      mem0[8'h11] <= 16'h1111;
      mem0[8'h05] <= 16'h5A5A;
      mem0[8'h07] <= 16'h7777;
      mem0[8'h09] <= 16'h9999;
    end else if (!ramEn0 && !ramWe0) begin
      mem0[ramAddr0[7:0]] <= ramData0;
    end
  end

  // ---------------- instance u3 (WAIT_CYC = 3) ----------------
  logic        ifReq3 = 1'b0, dmReq3 = 1'b0, dmWe3 = 1'b0;
  logic [15:0] ifAddr3 = 16'h0, dmAddr3 = 16'h0, dmWdata3 = 16'h0;
  logic [15:0] ifData3, dmRdata3;
  logic        ifAck3, dmAck3, stall3, ramEn3, ramOe3, ramWe3;
  logic [17:0] ramAddr3;
  wire  [15:0] ramData3;
  logic [15:0] mem3 [0:255];

  ram_arbiter #(.WAIT_CYC(3)) u3 (
    .Clk(clk), .Rst(rst),
    .If_req(ifReq3), .If_addr(ifAddr3), .If_data(ifData3), .If_ack(ifAck3),
    .Dm_req(dmReq3), .Dm_we(dmWe3), .Dm_addr(dmAddr3), .Dm_wdata(dmWdata3),
    .Dm_rdata(dmRdata3), .Dm_ack(dmAck3), .Stall(stall3),
    .Ram_EN(ramEn3), .Ram_OE(ramOe3), .Ram_WE(ramWe3),
    .Ram_address(ramAddr3), .Ram_data(ramData3)
  );

  assign ramData3 = (!ramEn3 && !ramOe3 && ramWe3) ? mem3[ramAddr3[7:0]] : 16'hzzzz;

  // SRAM model u3.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 16'h0000;
      mem3[8'h30] <= 16'h3333;
      mem3[8'h31] <= 16'h3131;
    end else if (!ramEn3 && !ramWe3) begin
      mem3[ramAddr3[7:0]] <= ramData3;
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({ramEn0, ramOe0, ramWe0, ifAck0, dmAck0, stall0} !== 6'b111000) begin
      errCount++;
      $display("FAIL reset_ctrl_u0: got %b expected 111000", {ramEn0, ramOe0, ramWe0, ifAck0, dmAck0, stall0});
    end
    checkCount++;
    if ({ifData0, dmRdata0, ramAddr0} !== 50'h0) begin
      errCount++;
      $display("FAIL reset_regs_u0: got if=%h dm=%h addr=%h expected all zero", ifData0, dmRdata0, ramAddr0);
    end
    checkCount++;
    if ({ramEn3, ramOe3, ramWe3, ifAck3, dmAck3, stall3, ifData3, dmRdata3, ramAddr3} !== {6'b111000, 50'h0}) begin
      errCount++;
      $display("FAIL reset_u3: got ctrl=%b if=%h dm=%h addr=%h expected 111000 and zeros",
               {ramEn3, ramOe3, ramWe3, ifAck3, dmAck3, stall3}, ifData3, dmRdata3, ramAddr3);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_dm_read;
    logic expEn, expOe, expAck, expStall;
    dmReq0 = 1'b1; dmWe0 = 1'b0; dmAddr0 = 16'h0010;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      expEn = !(c >= 1 && c <= 3);
      expOe = !(c == 1 || c == 2);
      expAck = (c == 3);
      expStall = (c <= 2);
      checkCount++;
      if ({ramEn0, ramOe0, ramWe0, dmAck0, ifAck0, stall0} !== {expEn, expOe, 1'b1, expAck, 1'b0, expStall}) begin
        errCount++;
        $display("FAIL dm_read_ctrl cycle %0d: got %b expected %b", c,
                 {ramEn0, ramOe0, ramWe0, dmAck0, ifAck0, stall0}, {expEn, expOe, 1'b1, expAck, 1'b0, expStall});
      end
      if (c >= 1 && c <= 3) begin
        checkCount++;
        if (ramAddr0 !== 18'h00010) begin
          errCount++;
          $display("FAIL dm_read_addr cycle %0d: got %h expected 00010", c, ramAddr0);
        end
      end
      if (c == 3) begin
        checkCount++;
        if (dmRdata0 !== 16'hBEEF) begin
          errCount++;
          $display("FAIL dm_read_data: got %h expected BEEF", dmRdata0);
        end
      end
      nextCycle();
      if (c == 3) dmReq0 = 1'b0;
    end
    checkCount++;
    if (ifData0 !== 16'h0000) begin
      errCount++;
      $display("FAIL dm_read_if_untouched: got %h expected 0000", ifData0);
    end
  endtask

  task automatic test_dm_write;
    logic expEn, expWe, expAck, expStall;
    dmReq0 = 1'b1; dmWe0 = 1'b1; dmAddr0 = 16'h0020; dmWdata0 = 16'h1234;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      expEn = !(c >= 1 && c <= 3);
      expWe = !(c == 2);
      expAck = (c == 3);
      expStall = (c <= 2);
      checkCount++;
      if ({ramEn0, ramOe0, ramWe0, dmAck0, stall0} !== {expEn, 1'b1, expWe, expAck, expStall}) begin
        errCount++;
        $display("FAIL dm_write_ctrl cycle %0d: got %b expected %b", c,
                 {ramEn0, ramOe0, ramWe0, dmAck0, stall0}, {expEn, 1'b1, expWe, expAck, expStall});
      end
      checkCount++;
      if (c >= 1 && c <= 3) begin
        if (ramData0 !== 16'h1234) begin
          errCount++;
          $display("FAIL dm_write_bus cycle %0d: got %h expected 1234", c, ramData0);
        end
      end else begin
        // An undriven bus reads as Z (or as 0 where Z is not modelled).
        if (ramData0 !== 16'hzzzz && ramData0 !== 16'h0000) begin
          errCount++;
          $display("FAIL dm_write_bus_idle cycle %0d: got %h expected zzzz", c, ramData0);
        end
      end
      nextCycle();
      if (c == 3) begin
        dmReq0 = 1'b0; dmWe0 = 1'b0;
      end
    end
    checkCount++;
    if (mem0[8'h20] !== 16'h1234 || dmRdata0 !== 16'hBEEF || ifData0 !== 16'h0000) begin
      errCount++;
      $display("FAIL dm_write_result: got mem=%h dm=%h if=%h expected 1234 BEEF 0000", mem0[8'h20], dmRdata0, ifData0);
    end
  endtask

  task automatic test_simultaneous;
    logic expEn, expDmAck, expIfAck, expStall;
    dmReq0 = 1'b1; dmWe0 = 1'b0; dmAddr0 = 16'h0011;
    ifReq0 = 1'b1; ifAddr0 = 16'h0007;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      expEn = !((c >= 1 && c <= 3) || (c >= 5 && c <= 7));
      expDmAck = (c == 3);
      expIfAck = (c == 7);
      expStall = (c <= 6);
      checkCount++;
      if ({ramEn0, dmAck0, ifAck0, stall0} !== {expEn, expDmAck, expIfAck, expStall}) begin
        errCount++;
        $display("FAIL simul_ctrl cycle %0d: got %b expected %b", c,
                 {ramEn0, dmAck0, ifAck0, stall0}, {expEn, expDmAck, expIfAck, expStall});
      end
      if (c == 3) begin
        checkCount++;
        if (dmRdata0 !== 16'h1111 || ramAddr0 !== 18'h00011) begin
          errCount++;
          $display("FAIL simul_dm: got data=%h addr=%h expected 1111 00011", dmRdata0, ramAddr0);
        end
      end
      if (c == 6) begin
        checkCount++;
        if (ramAddr0 !== 18'h00007) begin
          errCount++;
          $display("FAIL simul_if_addr: got %h expected 00007", ramAddr0);
        end
      end
      if (c == 7) begin
        checkCount++;
        if (ifData0 !== 16'h7777 || dmRdata0 !== 16'h1111) begin
          errCount++;
          $display("FAIL simul_if: got if=%h dm=%h expected 7777 1111", ifData0, dmRdata0);
        end
      end
      nextCycle();
      if (c == 3) dmReq0 = 1'b0;
      if (c == 7) ifReq0 = 1'b0;
    end
  endtask

  task automatic test_addr_change;
    ifReq0 = 1'b1; ifAddr0 = 16'h0005;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checkCount++;
        if (ramAddr0 !== 18'h00005) begin
          errCount++;
          $display("FAIL addr_hold cycle %0d: got %h expected 00005", c, ramAddr0);
        end
      end
      if (c == 3) begin
        checkCount++;
        if (ifAck0 !== 1'b1 || ifData0 !== 16'h5A5A) begin
          errCount++;
          $display("FAIL addr_change_data: got ack=%b data=%h expected 1 5A5A", ifAck0, ifData0);
        end
      end
      nextCycle();
      if (c == 1) ifAddr0 = 16'h0009;
      if (c == 3) ifReq0 = 1'b0;
    end
  endtask

  task automatic test_reset_mid_write;
    dmReq0 = 1'b1; dmWe0 = 1'b1; dmAddr0 = 16'h0040; dmWdata0 = 16'hAAAA;
    nextCycle();
    nextCycle();
    #2;
    checkCount++;
    if (ramWe0 !== 1'b0 || ramData0 !== 16'hAAAA) begin
      errCount++;
      $display("FAIL pre_reset_strobe: got we=%b data=%h expected 0 AAAA", ramWe0, ramData0);
    end
    rst = 1'b1;
    #1;
    checkCount++;
    if ({ramEn0, ramOe0, ramWe0, dmAck0, ifAck0} !== 5'b11100 || ramAddr0 !== 18'h0) begin
      errCount++;
      $display("FAIL async_reset_ctrl: got %b addr=%h expected 11100 00000", {ramEn0, ramOe0, ramWe0, dmAck0, ifAck0}, ramAddr0);
    end
    checkCount++;
    if (ramData0 !== 16'hzzzz && ramData0 !== 16'h0000) begin
      errCount++;
      $display("FAIL async_reset_bus: got %h expected zzzz", ramData0);
    end
    dmReq0 = 1'b0; dmWe0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount++;
      if ({ramEn0, ramOe0, ramWe0, dmAck0, ifAck0, stall0} !== 6'b111000 || dmRdata0 !== 16'h0 || ifData0 !== 16'h0) begin
        errCount++;
        $display("FAIL post_reset_idle cycle %0d: got %b dm=%h if=%h expected 111000 0000 0000", c,
                 {ramEn0, ramOe0, ramWe0, dmAck0, ifAck0, stall0}, dmRdata0, ifData0);
      end
      nextCycle();
    end
  endtask

  task automatic test_wait3;
    logic expEn, expOe, expAck, expStall;
    ifReq3 = 1'b1; ifAddr3 = 16'h0030;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      expEn = !((c >= 1 && c <= 5) || (c >= 7 && c <= 11));
      expOe = !((c >= 1 && c <= 4) || (c >= 7 && c <= 10));
      expAck = (c == 5 || c == 11);
      expStall = !(c == 5 || c >= 11);
      checkCount++;
      if ({ramEn3, ramOe3, ramWe3, ifAck3, dmAck3, stall3} !== {expEn, expOe, 1'b1, expAck, 1'b0, expStall}) begin
        errCount++;
        $display("FAIL wait3_ctrl cycle %0d: got %b expected %b", c,
                 {ramEn3, ramOe3, ramWe3, ifAck3, dmAck3, stall3}, {expEn, expOe, 1'b1, expAck, 1'b0, expStall});
      end
      if (c == 5 || c == 11) begin
        checkCount++;
        if (ifData3 !== ((c == 5) ? 16'h3333 : 16'h3131) || dmRdata3 !== 16'h0000) begin
          errCount++;
          $display("FAIL wait3_data cycle %0d: got if=%h dm=%h expected %h 0000", c, ifData3, dmRdata3,
                   (c == 5) ? 16'h3333 : 16'h3131);
        end
      end
      nextCycle();
      if (c == 5) ifAddr3 = 16'h0031;
      if (c == 11) ifReq3 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_dm_read();
    test_dm_write();
    test_simultaneous();
    test_addr_change();
    test_reset_mid_write();
    test_wait3();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
